// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: the two writeback producers, the decode
// issue/hazard port and the registered register-file write port.
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // ALU writeback producer
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  // Load/store unit writeback producer
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              lsu_ready;

  // Decode: destination dispatch and source hazard lookup
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic              hazard1;
  logic              hazard2;

  // Register file write port and status
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              idle;

  // Producer/decode side
  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_addr, lsu_data,
    input  lsu_ready,
    output issue_valid, issue_addr,
    input  issue_ready,
    output A1, A2,
    input  hazard1, hazard2,
    input  WE3, A3, WD3, idle
  );

  // Scheduler side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_addr, lsu_data,
    output lsu_ready,
    input  issue_valid, issue_addr,
    output issue_ready,
    input  A1, A2,
    output hazard1, hazard2,
    output WE3, A3, WD3, idle
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for a single-write-port register file.
// Round-robin arbitration between ALU and LSU writebacks, a one-entry
// registered write port (WE3/A3/WD3), and a per-register busy scoreboard
// used by decode for RAW hazard detection and WAW issue stalls.
module regfile_wb_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic                CLK,
  input logic                rst,
  regfile_wb_scheduler_if.slave bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e                rr_last;
  src_e                rr_next;

  logic                alu_grant;
  logic                lsu_grant;
  logic                win_fire;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                we_nxt;

  logic                we_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   data_p1;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                issue_fire;

  // Round-robin grant: a lone requester always wins; on a conflict the
  // requester that did not win last time wins.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (bus.alu_valid && bus.lsu_valid) begin
      alu_grant = (rr_last == SRC_LSU);
      lsu_grant = (rr_last == SRC_ALU);
    end else begin
      alu_grant = bus.alu_valid;
      lsu_grant = bus.lsu_valid;
    end
  end

  assign bus.alu_ready = alu_grant;
  assign bus.lsu_ready = lsu_grant;

  // Select the winning request; register 0 writes are accepted but dropped.
  always_comb begin
    win_fire = alu_grant || lsu_grant;
    win_addr = bus.lsu_addr;
    win_data = bus.lsu_data;
    if (alu_grant) begin
      win_addr = bus.alu_addr;
      win_data = bus.alu_data;
    end
    we_nxt = win_fire && (win_addr != '0);
  end

  // Next round-robin pointer follows the requester granted this cycle.
  always_comb begin
    rr_next = rr_last;
    if (alu_grant) begin
      rr_next = SRC_ALU;
    end else if (lsu_grant) begin
      rr_next = SRC_LSU;
    end
  end

  // Round-robin pointer register; after reset the ALU wins the first conflict.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rr_last <= SRC_LSU;
    end else begin
      rr_last <= rr_next;
    end
  end

  // ---- stage p0 -> p1: accepted writeback becomes the register file write ----
  // The output register is refilled every cycle; address/data only load on a
  // transfer so they stay quiet while the port is idle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      we_p1 <= we_nxt;
      if (win_fire) begin
        addr_p1 <= win_addr;
        data_p1 <= win_data;
      end
    end
  end

  assign bus.WE3 = we_p1;
  assign bus.A3  = addr_p1;
  assign bus.WD3 = data_p1;

  // A destination may be re-issued in the very cycle its pending write lands.
  always_comb begin
    bus.issue_ready = 1'b1;
    if (bus.issue_addr != '0) begin
      bus.issue_ready = !busy[bus.issue_addr] ||
                        (we_p1 && (addr_p1 == bus.issue_addr));
    end
  end

  assign issue_fire = bus.issue_valid && bus.issue_ready &&
                      (bus.issue_addr != '0);

  // Scoreboard update: clear on the landing write, then a same-cycle issue
  // to the same register re-sets it. Register 0 is never tracked.
  always_comb begin
    busy_nxt = busy;
    if (we_p1) begin
      busy_nxt[addr_p1] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[bus.issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Hazards drop the cycle after the write lands, when the register file
  // read already returns the new value, so no bypass path is needed.
  assign bus.hazard1 = busy[bus.A1] && (bus.A1 != '0);
  assign bus.hazard2 = busy[bus.A2] && (bus.A2 != '0);
  assign bus.idle    = (busy == '0) && !we_p1;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: directed writeback/issue
// vectors push expected register-file writes, an independent monitor pops
// and compares them whenever WE3 is presented.
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic rst;

  always #5 CLK = ~CLK;

  regfile_wb_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t expq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    expq.push_back(w);
  endtask

  // Present ALU/LSU requests at the falling edge, check the expected grants,
  // and queue the write each expected grant must produce.
  task automatic apply(input logic av, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic lv,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic ea, input logic el);
    @(negedge CLK);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_addr = la; bus.lsu_data = ld;
    #1;
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, ea});
    chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, el});
    if (ea && aa != '0) push_wr(aa, ad);
    if (el && la != '0) push_wr(la, ld);
  endtask

  task automatic clr_wb();
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(posedge CLK) begin : mon
    wr_t e;
    #1;
    if (!rst && bus.WE3) begin
      if (expq.size() == 0) begin
        chk("unexpected_we3", {27'd0, bus.A3}, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("wb_addr", {27'd0, bus.A3}, {27'd0, e.a});
        chk("wb_data", bus.WD3, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acnt;
    int lcnt;
    logic ea;

    // Reset with a pending ALU request
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h0000_0011;
    bus.lsu_valid = 1'b0; bus.lsu_addr = '0;   bus.lsu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_addr = '0;
    bus.A1 = 5'd1; bus.A2 = 5'd2;
    #12;
    @(negedge CLK); #1;
    chk("rst_we3", {31'd0, bus.WE3}, 32'd0);
    chk("rst_a3", {27'd0, bus.A3}, 32'd0);
    chk("rst_wd3", bus.WD3, 32'd0);
    chk("rst_idle", {31'd0, bus.idle}, 32'd1);
    chk("rst_hazard1", {31'd0, bus.hazard1}, 32'd0);
    chk("rst_hazard2", {31'd0, bus.hazard2}, 32'd0);

    @(negedge CLK);
    rst = 1'b0;
    #1;
    chk("rel_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    push_wr(5'd1, 32'h0000_0011);

    // Single ALU write to a scoreboarded register
    @(negedge CLK);
    clr_wb();
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd5; bus.A1 = 5'd5;
    #1;
    chk("rel_we3", {31'd0, bus.WE3}, 32'd1);
    chk("issue5_ready", {31'd0, bus.issue_ready}, 32'd1);
    @(negedge CLK);
    bus.issue_valid = 1'b0;
    #1;
    chk("busy5_hazard1", {31'd0, bus.hazard1}, 32'd1);
    chk("busy5_idle", {31'd0, bus.idle}, 32'd0);
    apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge CLK);
    clr_wb();
    #1;
    chk("wb5_we3", {31'd0, bus.WE3}, 32'd1);
    chk("wb5_hazard1_held", {31'd0, bus.hazard1}, 32'd1);
    @(negedge CLK); #1;
    chk("wb5_hazard1_clear", {31'd0, bus.hazard1}, 32'd0);
    chk("wb5_idle", {31'd0, bus.idle}, 32'd1);

    // Conflict fairness from a fresh reset: ALU, LSU, ALU, ...
    @(negedge CLK);
    rst = 1'b1;
    #2 rst = 1'b0;
    acnt = 0;
    lcnt = 0;
    for (int i = 0; i < 6; i++) begin
      ea = (i % 2 == 0);
      apply(1'b1, 5'd3, 32'hA000_0000 + acnt, 1'b1, 5'd4, 32'hB000_0000 + lcnt,
            ea, !ea);
      if (ea) acnt++;
      else lcnt++;
    end

    // WAW stall on register 7 and same-cycle release with set priority
    @(negedge CLK);
    clr_wb();
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    #1;
    chk("issue7_ready", {31'd0, bus.issue_ready}, 32'd1);
    apply(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1);
    chk("waw_stall", {31'd0, bus.issue_ready}, 32'd0);
    @(negedge CLK);
    clr_wb();
    #1;
    chk("waw_we3", {31'd0, bus.WE3}, 32'd1);
    chk("waw_release", {31'd0, bus.issue_ready}, 32'd1);
    @(negedge CLK);
    bus.issue_valid = 1'b0; bus.A2 = 5'd7;
    #1;
    chk("set_wins_hazard2", {31'd0, bus.hazard2}, 32'd1);
    chk("set_wins_idle", {31'd0, bus.idle}, 32'd0);
    apply(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0078, 1'b0, 1'b1);
    @(negedge CLK);
    clr_wb();
    @(negedge CLK); #1;
    chk("wb7_hazard2_clear", {31'd0, bus.hazard2}, 32'd0);
    chk("wb7_idle", {31'd0, bus.idle}, 32'd1);

    // Register 0: accepted, never written, never scoreboarded
    apply(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1);
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
    #1;
    chk("r0_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
    @(negedge CLK);
    clr_wb();
    bus.issue_valid = 1'b0;
    #1;
    chk("r0_we3", {31'd0, bus.WE3}, 32'd0);
    chk("r0_idle", {31'd0, bus.idle}, 32'd1);

    // Reset landing on an in-flight write
    @(negedge CLK);
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9; bus.A1 = 5'd9;
    @(negedge CLK);
    bus.issue_valid = 1'b0;
    apply(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge CLK);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_we3", {31'd0, bus.WE3}, 32'd0);
    chk("midrst_a3", {27'd0, bus.A3}, 32'd0);
    chk("midrst_wd3", bus.WD3, 32'd0);
    chk("midrst_idle", {31'd0, bus.idle}, 32'd1);
    chk("midrst_hazard1", {31'd0, bus.hazard1}, 32'd0);
    clr_wb();
    #2 rst = 1'b0;
    @(negedge CLK); #1;
    chk("postrst_we3", {31'd0, bus.WE3}, 32'd0);
    chk("postrst_idle", {31'd0, bus.idle}, 32'd1);

    repeat (3) @(posedge CLK);
    #2;
    chk("queue_empty", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Schedules all writebacks into the single-write-port 32x32 register file. Two producers compete for the port: the ALU path and the load/store unit (LSU). The block arbitrates between them round-robin and registers the winning write onto WE3/A3/WD3. It also keeps a per-register busy scoreboard, so decode can detect RAW hazards and stall WAW issue.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers tracked by the scoreboard (2**ADDR_W)

Ports:
CLK  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle
lsu_valid  input  1  LSU writeback request
lsu_addr  input  ADDR_W  LSU destination register
lsu_data  input  DATA_W  load data
lsu_ready  output  1  LSU request accepted this cycle
issue_valid  input  1  decode dispatches an instruction with a destination
issue_addr  input  ADDR_W  destination of the dispatched instruction
issue_ready  output  1  dispatch accepted (no WAW conflict)
A1  input  ADDR_W  decode source operand 1 address
A2  input  ADDR_W  decode source operand 2 address
hazard1  output  1  A1 has a write outstanding
hazard2  output  1  A2 has a write outstanding
WE3  output  1  register file write enable (registered)
A3  output  ADDR_W  register file write address (registered)
WD3  output  DATA_W  register file write data (registered)
idle  output  1  no busy register and no write in flight

Behaviour:
- Reset (async, rst=1):
  - WE3=0, A3=0, WD3=0.
  - busy[]=0, rr_last=LSU, so the ALU wins the first conflict.
  - Any in-flight write is dropped. Outputs hold these values while rst=1.
- Transfer rule: a request transfers in a cycle where valid&&ready. Ready is combinational from the valids and rr_last.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not equal to rr_last gets ready=1; the other gets 0.
  - Neither valid: both readies 0.
  - rr_last updates to the granted requester on each transfer.
- A requester must hold valid, addr and data stable until accepted.
- Latency: a transfer in cycle N drives WE3/A3/WD3 in cycle N+1 (one-entry output register, refilled every cycle). No back-pressure exists from the register file.
- Register 0: a transfer with addr=0 is accepted (ready=1) but produces WE3=0 in N+1, with A3/WD3 don't-care. It never affects the scoreboard.
- Scoreboard busy[r], r=1..NUM_REGS-1:
  - Set on issue_valid && issue_ready && issue_addr!=0.
  - Clear on the edge ending a cycle with WE3=1 && A3==r. This is the same edge at which the register file captures WD3.
  - Set and clear of the same r in the same cycle: set wins.
- issue_ready = !busy[issue_addr] || (WE3 && A3==issue_addr). issue_addr=0 is always ready.
- hazard1 = busy[A1] && A1!=0, combinational. hazard2 is the same for A2.
  - Hazard falls in the cycle after the WE3 cycle. This is the same cycle the register file read returns the new value, so no bypass is needed.
- idle = (busy==0) && !WE3.
- Writebacks to a non-busy register (e.g. speculative/unscoreboarded) are legal: written normally, scoreboard unchanged.
- Reset asserted mid-operation: the pending WE3 is cancelled asynchronously and busy is cleared. Producers must drop requests; a valid held through reset deassertion is arbitrated normally afterwards.

Test Plan:
- Reset: drive rst=1 with alu_valid=1 -> WE3=0, A3=0, WD3=0, idle=1, hazard1=hazard2=0. Release rst -> ALU transfers; next cycle WE3=1.
- Single ALU write: issue_addr=5 -> busy[5]=1, A1=5 gives hazard1=1. alu_valid, addr=5, data=0xDEADBEEF in cycle N -> cycle N+1: WE3=1, A3=5, WD3=0xDEADBEEF; cycle N+2: hazard1=0, idle=1.
- Conflict fairness: both valid every cycle for 6 cycles (ALU addr 3, LSU addr 4) -> grants alternate ALU, LSU, ALU, ... starting with ALU. WE3 high every cycle with A3 sequence 3,4,3,4,3,4.
- WAW stall: busy[7]=1, issue_addr=7 -> issue_ready=0. In the WE3=1, A3=7 cycle -> issue_ready=1, and after the edge busy[7] remains 1 (set wins).
- Register 0: lsu_valid, addr=0, data=0x1234 -> lsu_ready=1, next cycle WE3=0. issue_addr=0 -> issue_ready=1, busy unchanged.
- Mid-write reset: transfer in cycle N, rst pulsed asynchronously before edge N+1 -> WE3=0 immediately, busy all zero, idle=1.
